// File: rtl/flash_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flash_arbiter: round-robin arbiter and command sequencer for the shared   |
// | flash array. Optional watchdog: define FLASH_ARB_TIMEOUT_EN.              |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module flash_arbiter #(
  parameter int NUM_REQ     = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [2*NUM_REQ-1:0] req_op,
  input  logic [8*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_data,
  output logic                 rsp_err,
  output logic [7:0]           mem_addr,
  output logic [7:0]           mem_data_in,
  output logic [3:0]           mem_pid,
  output logic                 mem_read_enable,
  output logic                 mem_write_enable,
  output logic                 mem_erase,
  input  logic [7:0]           mem_data_out,
  input  logic                 mem_out_ready,
  input  logic                 mem_readwrite_valid,
  input  logic                 mem_erase_done,
  input  logic                 mem_error,
  input  logic                 mem_busy_flash
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] c_OP_READ    = 2'b00;
  localparam logic [1:0] c_OP_WRITE   = 2'b01;
  localparam logic [1:0] c_OP_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_RELEASE = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t           r_state, w_next;
  logic [IDX_W-1:0] r_last_grant, r_winner, w_grant;
  logic             w_found;
  logic [1:0]       r_op, w_op;
  logic [7:0]       r_addr, r_wdata, r_rdata, w_addr, w_wdata;
  logic             r_err;
  logic             w_done, w_en, w_timeout;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    int               k;
    logic [IDX_W-1:0] idx;
    w_found = 1'b0;
    w_grant = r_last_grant;
    k       = 0;
    idx     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k   = (int'(r_last_grant) + i) % NUM_REQ;
      idx = IDX_W'(k);
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_grant = idx;
      end
    end
  end

  always_comb begin
    w_op    = '0;
    w_addr  = '0;
    w_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == IDX_W'(i)) begin
        w_op    = req_op[2*i +: 2];
        w_addr  = req_addr[8*i +: 8];
        w_wdata = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    case (r_op)
      c_OP_READ:  w_done = mem_out_ready;
      c_OP_WRITE: w_done = mem_readwrite_valid;
      default:    w_done = mem_erase_done;
    endcase
  end

`ifdef FLASH_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_WAIT || r_state == S_RELEASE) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign w_timeout = (r_state == S_WAIT || r_state == S_RELEASE) &&
                     (r_tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    rsp_valid = '0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    w_en      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Gated by reset so no accept pulse escapes while held in reset.
        if (w_found && rst) begin
          req_ready[w_grant] = 1'b1;
          w_next = (w_op == c_OP_ILLEGAL) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_en   = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        w_en = 1'b1;
        if (mem_error || w_done) begin
          w_next = S_RELEASE;
        end else if (w_timeout) begin
          w_next = S_RESP;
        end
      end
      S_RELEASE: begin
        if ((!w_done && !mem_error && !mem_busy_flash) || w_timeout) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid[r_winner] = 1'b1;
        rsp_data            = r_rdata;
        rsp_err             = r_err;
        w_next              = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign mem_read_enable  = w_en && (r_op == c_OP_READ);
  assign mem_write_enable = w_en && (r_op == c_OP_WRITE);
  assign mem_erase        = w_en && (r_op == 2'b10);
  assign mem_addr         = r_addr;
  assign mem_data_in      = r_wdata;
  assign mem_pid          = 4'(r_winner);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_winner     <= '0;
      r_op         <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_winner <= w_grant;
            r_op     <= w_op;
            r_addr   <= w_addr;
            r_wdata  <= w_wdata;
            r_rdata  <= '0;
            r_err    <= (w_op == c_OP_ILLEGAL);
          end
        end
        S_WAIT: begin
          // Error wins over a simultaneous done flag.
          if (mem_error) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end else if (w_done) begin
            if (r_op == c_OP_READ) r_rdata <= mem_data_out;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        S_RELEASE: begin
          if (w_timeout && (w_done || mem_error || mem_busy_flash)) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end
        end
        S_RESP:  r_last_grant <= r_winner;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flash_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_flash_arbiter: directed bench for flash_arbiter with a behavioural     |
// | flash array and response/grant scoreboards.                               |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_flash_arbiter;

  localparam int NUM_REQ = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req_valid;
  logic [9:0]  req_op;
  logic [39:0] req_addr, req_data;
  logic [4:0]  req_ready, rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [7:0]  mem_addr, mem_data_in, mem_data_out;
  logic [3:0]  mem_pid;
  logic        mem_read_enable, mem_write_enable, mem_erase;
  logic        mem_out_ready, mem_readwrite_valid, mem_erase_done, mem_error, mem_busy_flash;

  always #5 clk = ~clk;

  flash_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYC(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_pid(mem_pid),
    .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable), .mem_erase(mem_erase),
    .mem_data_out(mem_data_out), .mem_out_ready(mem_out_ready),
    .mem_readwrite_valid(mem_readwrite_valid), .mem_erase_done(mem_erase_done),
    .mem_error(mem_error), .mem_busy_flash(mem_busy_flash)
  );

  // Behavioural array: completes 4 cycles after an enable rises, holds flags until it drops.
  logic [7:0] fmem [0:7][0:255];
  logic       loaded = 1'b0;
  int         lat_cnt = 0;
  logic       hang = 1'b0, inject_err = 1'b0, inject_both = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int p = 0; p < 8; p++)
        for (int a = 0; a < 256; a++) fmem[p][a] <= 8'(a);
      loaded <= 1'b1;
    end
    if (mem_read_enable | mem_write_enable | mem_erase) begin
      mem_busy_flash <= 1'b1;
      if (lat_cnt < 3) begin
        lat_cnt <= lat_cnt + 1;
      end else if (!hang) begin
        if (inject_err) begin
          mem_error <= 1'b1;
        end else if (mem_read_enable) begin
          mem_out_ready <= 1'b1;
          mem_data_out  <= inject_both ? 8'h77 : fmem[mem_pid[2:0]][mem_addr];
          if (inject_both) mem_error <= 1'b1;
        end else if (mem_write_enable) begin
          mem_readwrite_valid <= 1'b1;
          fmem[mem_pid[2:0]][mem_addr] <= mem_data_in;
        end else begin
          mem_erase_done <= 1'b1;
          for (int a = 0; a < 256; a++) fmem[mem_pid[2:0]][a] <= 8'hFF;
        end
      end
    end else begin
      lat_cnt             <= 0;
      mem_busy_flash      <= 1'b0;
      mem_out_ready       <= 1'b0;
      mem_readwrite_valid <= 1'b0;
      mem_erase_done      <= 1'b0;
      mem_error           <= 1'b0;
      mem_data_out        <= 8'h00;
    end
  end

  typedef struct packed {
    logic [2:0] pid;
    logic [7:0] data;
    logic       err;
  } rsp_t;

  rsp_t       exp_rsp[$];
  logic [4:0] exp_grant[$];
  int         n_assert = 0;
  int         n_fail   = 0;

  logic [4:0] s_ready, s_rsp;
  logic       s_rd, s_wr, s_er, s_err;
  logic [3:0] s_pid;
  logic [7:0] s_addr, s_din, s_rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One clock: sample at negedge, score grants/responses, release accepted requests.
  task automatic step();
    rsp_t       e;
    logic [4:0] g;
    @(negedge clk);
    s_ready = req_ready;  s_rsp = rsp_valid;  s_rdata = rsp_data;  s_err = rsp_err;
    s_rd = mem_read_enable;  s_wr = mem_write_enable;  s_er = mem_erase;
    s_pid = mem_pid;  s_addr = mem_addr;  s_din = mem_data_in;
    if (s_ready != 5'd0) begin
      if (exp_grant.size() == 0) begin
        check("unexpected_grant", 32'(s_ready), 32'(0));
      end else begin
        g = exp_grant.pop_front();
        check("grant", 32'(s_ready), 32'(g));
      end
    end
    if ({s_rd, s_wr, s_er} != 3'b000)
      check("enable_onehot", 32'($onehot({s_rd, s_wr, s_er})), 32'(1));
    if (s_rsp != 5'd0) begin
      if (exp_rsp.size() == 0) begin
        check("unexpected_rsp", 32'(s_rsp), 32'(0));
      end else begin
        e = exp_rsp.pop_front();
        check("rsp_valid", 32'(s_rsp), 32'(1) << e.pid);
        check("rsp_data", 32'(s_rdata), 32'(e.data));
        check("rsp_err", 32'(s_err), 32'(e.err));
      end
    end
    @(posedge clk);
    #1;
    req_valid = req_valid & ~s_ready;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && (exp_rsp.size() != 0 || exp_grant.size() != 0); k++) step();
    check("drain_rsp_left", 32'(exp_rsp.size()), 32'(0));
    check("drain_grant_left", 32'(exp_grant.size()), 32'(0));
  endtask

  task automatic set_req(input int pid, input logic [1:0] op, input logic [7:0] addr,
                         input logic [7:0] wdata);
    req_op[2*pid +: 2]   = op;
    req_addr[8*pid +: 8] = addr;
    req_data[8*pid +: 8] = wdata;
  endtask

  task automatic issue_one(input int pid, input logic [1:0] op, input logic [7:0] addr,
                           input logic [7:0] wdata, input logic [7:0] exp_data,
                           input logic exp_err, input int budget);
    logic       got;
    logic [4:0] mask;
    logic [2:0] exp_en;
    mask = 5'(32'(1) << pid);
    set_req(pid, op, addr, wdata);
    exp_grant.push_back(mask);
    exp_rsp.push_back('{3'(pid), exp_data, exp_err});
    req_valid[pid] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      got = ((s_ready & mask) != 5'd0);
    end
    check("grant_seen", 32'(got), 32'(1));
    step();
    if (op == 2'b11) begin
      check("illegal_rsp_next_cycle", 32'(s_rsp), 32'(mask));
      check("illegal_no_enable", 32'({s_rd, s_wr, s_er}), 32'(0));
    end else begin
      exp_en = (op == 2'b00) ? 3'b100 : (op == 2'b01) ? 3'b010 : 3'b001;
      check("enable_after_ready", 32'({s_rd, s_wr, s_er}), 32'(exp_en));
      check("mem_pid", 32'(s_pid), 32'(pid));
      check("mem_addr", 32'(s_addr), 32'(addr));
      if (op == 2'b01) check("mem_data_in", 32'(s_din), 32'(wdata));
    end
    drain(budget);
  endtask

  initial begin
    logic got;
    rst = 1'b0;
    req_valid = '0;
    req_op = '0;
    req_addr = '0;
    req_data = '0;
    // All five requesters pending while reset is held.
    for (int p = 0; p < NUM_REQ; p++) set_req(p, 2'b00, 8'(8'h20 + p), 8'h00);
    req_valid = 5'h1F;
    #22;
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_data", 32'(rsp_data), 32'(0));
    check("rst_rsp_err", 32'(rsp_err), 32'(0));
    check("rst_enables", 32'({mem_read_enable, mem_write_enable, mem_erase}), 32'(0));
    check("rst_mem_addr", 32'(mem_addr), 32'(0));
    check("rst_mem_pid", 32'(mem_pid), 32'(0));
    check("rst_mem_data_in", 32'(mem_data_in), 32'(0));

    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int p = 0; p < NUM_REQ; p++) begin
      exp_grant.push_back(5'(32'(1) << p));
      exp_rsp.push_back('{3'(p), 8'(8'h20 + p), 1'b0});
    end
    drain(200);

    // Wrap-around: last winner 4, so PID 0 precedes PID 3.
    set_req(0, 2'b00, 8'h30, 8'h00);
    set_req(3, 2'b00, 8'h33, 8'h00);
    exp_grant.push_back(5'b00001);  exp_rsp.push_back('{3'd0, 8'h30, 1'b0});
    exp_grant.push_back(5'b01000);  exp_rsp.push_back('{3'd3, 8'h33, 1'b0});
    req_valid = 5'b01001;
    drain(80);

    issue_one(2, 2'b00, 8'h10, 8'h00, 8'h10, 1'b0, 40);
    issue_one(1, 2'b01, 8'h03, 8'hA5, 8'h00, 1'b0, 40);
    issue_one(1, 2'b00, 8'h03, 8'h00, 8'hA5, 1'b0, 40);
    issue_one(4, 2'b11, 8'h00, 8'h00, 8'h00, 1'b1, 10);
    issue_one(1, 2'b10, 8'h00, 8'h00, 8'h00, 1'b0, 40);
    issue_one(1, 2'b00, 8'h03, 8'h00, 8'hFF, 1'b0, 40);

    inject_err = 1'b1;
    issue_one(3, 2'b00, 8'h05, 8'h00, 8'h00, 1'b1, 40);
    inject_err = 1'b0;

    inject_both = 1'b1;
    issue_one(0, 2'b00, 8'h10, 8'h00, 8'h00, 1'b1, 40);
    inject_both = 1'b0;

    // Reset in the middle of a hung read: enables must drop at once, no response.
    hang = 1'b1;
    set_req(0, 2'b00, 8'h22, 8'h00);
    exp_grant.push_back(5'b00001);
    req_valid[0] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      got = s_ready[0];
    end
    check("rst_case_grant_seen", 32'(got), 32'(1));
    step();
    step();
    check("rd_en_in_wait", 32'(s_rd), 32'(1));
    #2;
    rst = 1'b0;
    #1;
    check("midrst_enables", 32'({mem_read_enable, mem_write_enable, mem_erase}), 32'(0));
    check("midrst_rsp_valid", 32'(rsp_valid), 32'(0));
    repeat (3) step();
    rst = 1'b1;
    hang = 1'b0;
    repeat (4) step();

    // last_grant back at NUM_REQ-1 after reset, so PID 0 wins over PID 1.
    set_req(0, 2'b00, 8'h40, 8'h00);
    set_req(1, 2'b00, 8'h05, 8'h00);
    exp_grant.push_back(5'b00001);  exp_rsp.push_back('{3'd0, 8'h40, 1'b0});
    exp_grant.push_back(5'b00010);  exp_rsp.push_back('{3'd1, 8'hFF, 1'b0});
    req_valid = 5'b00011;
    drain(80);

`ifdef FLASH_ARB_TIMEOUT_EN
    hang = 1'b1;
    issue_one(2, 2'b00, 8'h01, 8'h00, 8'h00, 1'b1, 200);
    hang = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/flash_arbiter.md
# flash_arbiter

Round-robin arbiter and command sequencer that shares the single flash memory array between up to five per-process requesters, one per PID. It accepts read, write and erase requests and issues them one at a time on the array's level-enable interface. It waits for the array's completion or error flag, then returns a one-cycle response to the winning requester. It sits between the process-side logic and the memory array and is the only block that drives the array's command inputs.

## Interface
- NUM_REQ, 5, number of requesters; requester index is the PID driven to the array (0..NUM_REQ-1).
- TIMEOUT_CYC, 64, watchdog limit in cycles for the WAIT and RELEASE states (used only with the macro).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request pending; held until req_ready.
- req_op  in  2*NUM_REQ  per-requester op: 00 read, 01 write, 10 erase, 11 illegal.
- req_addr  in  8*NUM_REQ  per-requester byte address within its PID page space.
- req_data  in  8*NUM_REQ  per-requester write data.
- req_ready  out  NUM_REQ  one-cycle accept pulse to the winner; request fields latched that cycle.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the requester being served.
- rsp_data  out  8  read data; 0 for write, erase and error responses; valid with rsp_valid.
- rsp_err  out  1  error flag; valid with rsp_valid.
- mem_addr, mem_data_in  out  8 each  array address and write data.
- mem_pid  out  4  array PID.
- mem_read_enable, mem_write_enable, mem_erase  out  1 each  level command enables; at most one high.
- mem_data_out  in  8  array read data.
- mem_out_ready, mem_readwrite_valid, mem_erase_done, mem_error, mem_busy_flash  in  1 each  array status.

## Operation
- States: IDLE, ISSUE, WAIT, RELEASE, RESP.
- IDLE: if any req_valid is high, pick the winner by round-robin, searching from last_grant+1 modulo NUM_REQ. Pulse req_ready[winner]. Latch op, addr and data.
  - Op 11 goes to RESP with rsp_err=1; the array is not touched.
  - Any other op goes to ISSUE.
- ISSUE: drive mem_addr, mem_data_in and mem_pid=winner. Raise exactly one enable matching the op. Go to WAIT.
- WAIT: hold the enable until the matching done flag (out_ready, readwrite_valid or erase_done) or mem_error is seen.
  - On read done, capture mem_data_out.
  - On mem_error, set err.
  - In both cases, drop the enable and go to RELEASE.
- RELEASE: stay until the matching done flag, mem_error and mem_busy_flash are all low, then go to RESP.
- RESP: pulse rsp_valid[winner] with rsp_data and rsp_err. Set last_grant=winner. Go to IDLE.
- mem_addr, mem_data_in and mem_pid hold stable from ISSUE through the end of RELEASE.
- Only one transaction is outstanding at a time. Requests not selected stay pending; no request is dropped.

## Timing
- Reset values: all outputs 0, all enables low, state IDLE, last_grant=NUM_REQ-1 (so PID 0 has first priority).
- Reset asserted mid-transaction:
  - Enables drop immediately and no response is issued.
  - The requester must re-request.
- Command enable goes high on the cycle after req_ready.
- rsp_valid comes at least 2 cycles after the done or error flag is first sampled (WAIT→RELEASE→RESP, given the flag clears in 1 cycle).
- Illegal op: rsp_valid 1 cycle after req_ready.
- Done flag and mem_error sampled in the same cycle: treated as an error. rsp_err=1, rsp_data=0.
- Back-to-back requests: next arbitration happens in the IDLE cycle following RESP, giving a minimum 1-cycle gap between commands.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,3,4,0,… and each waits at most NUM_REQ-1 transactions.

## Configuration
- FLASH_ARB_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT and RELEASE and clears on entry to ISSUE.
  - When it reaches TIMEOUT_CYC, the enable is dropped and the block goes directly to RESP with rsp_err=1, rsp_data=0.
- FLASH_ARB_TIMEOUT_EN undefined:
  - No counter is built.
  - WAIT and RELEASE wait indefinitely.

## Test plan
- Read, PID 2, addr 0x10, array returns 0x10 -> req_ready[2] pulse, mem_read_enable high with mem_pid=2, then rsp_valid[2] with rsp_data=0x10, rsp_err=0.
- Write 0xA5 to PID 1 addr 0x03, then read it back -> mem_write_enable cycle with mem_data_in=0xA5, then read response rsp_data=0xA5.
- All five requesters valid simultaneously from reset -> grant order 0,1,2,3,4, then 0 again. Never more than one enable high.
- Op 11 from PID 4 -> rsp_valid[4], rsp_err=1 one cycle after req_ready. No enable asserted.
- Array asserts mem_error during WAIT -> enable drops, rsp_err=1, rsp_data=0.
- With FLASH_ARB_TIMEOUT_EN, array never completes -> rsp_err=1 at TIMEOUT_CYC cycles into WAIT. Assert rst low mid-WAIT -> enables 0 within the same cycle, no rsp_valid.
